pdm_cic_decimator: RTL and testbench
====================================

// Module: pdm_cic_decimator
// PURPOSE
// - Receive end of the PDM link: takes a 1-bit PDM stream clocked on addr_clk (mic or PDM generator loopback),
//   converts it to signed PCM through an N-stage CIC decimator, and presents the samples on a valid/ready port.
// - Sits between the mic-array PDM inputs and the downstream beamforming/PCM buffering logic.
// PARAMETERS
// - N      3   CIC order: number of integrator stages and number of comb stages
// - DECIM  64  decimation ratio R, power of two, 2..256; comb differential delay fixed at 1
// - OUT_W  16  PCM output width, signed
// - ACC_W  derived = N*clog2(DECIM)+2 (20 at defaults); internal two's-complement width
// PORTS
// - addr_clk   in   1      PDM bit clock; one PDM bit per rising edge
// - reset      in   1      synchronous, active-high
// - pdm_in     in   1      PDM data, MSB-first serial order; 1 -> +1, 0 -> -1
// - pcm_out    out  OUT_W  signed PCM sample, held while pcm_valid && !pcm_ready
// - pcm_valid  out  1      sample available
// - pcm_ready  in   1      consumer accepts the sample on an edge where pcm_valid && pcm_ready
// - overrun    out  1      sticky: an unaccepted sample was overwritten
// BEHAVIOUR
// - Reset state (reset sampled high on addr_clk): all integrators, comb delays and pipeline registers are 0;
//   phase counter = 0; settle counter = 0; pcm_out = 0; pcm_valid = 0; overrun = 0.
// - Reset mid-operation discards all pipeline contents; no partial sample is emitted afterwards.
// - Input: pdm_in is registered once (pdm_q), then mapped to +1/-1 at width ACC_W.
// - Integrators: every edge, I1 += x and Ik += I(k-1). Arithmetic is modulo 2^ACC_W; wrap-around is
//   intended and must not be saturated or flagged.
// - Decimation: the phase counter runs 0..DECIM-1 and wraps. The edge on which phase == DECIM-1 is the
//   strobe; on it, IN is captured into comb stage 1.
// - Combs: N registered stages. On the strobe-propagated enable, Ck = in - dly and dly <= in.
//   One stage per addr_clk edge, so the comb result is ready N edges after the strobe.
// - Scaling: shift the comb result arithmetically right by N*clog2(DECIM)+1-OUT_W (3 at defaults).
//   Saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. At defaults, all-ones gives +2^15, which saturates to 32767.
// - Output register: loaded N+1 edges after the strobe. Total latency from the strobe's pdm bit is N+2 edges.
// - Settling: the first N decimated results after reset are dropped, because the comb delays are not yet
//   valid. A settle counter saturates at N; loads are enabled only once it equals N.
// - Handshake: pcm_valid rises on the load edge and stays high until accepted.
//   - Accept only, no load: pcm_valid <= 0.
//   - Load while pcm_valid && !pcm_ready: overwrite pcm_out, keep pcm_valid = 1, set overrun = 1.
//   - Load and accept on the same edge: the old sample is consumed, the new one is loaded, pcm_valid stays 1,
//     and overrun is not set.
// - overrun clears only on reset.
// - pcm_out never changes while pcm_valid && !pcm_ready, except when overwritten on an overrun.
// STRUCTURE
// - Shared package pdm_pkg holds:
//   - PDM_WORD_W = 8 (wavetable word width, big-endian)
//   - PDM_WT_SIZE = 1000
//   - clog2 function
//   - CIC defaults: N, DECIM, OUT_W
//   - ACC_W derivation macro
// - One sub-module: cic_comb_stage (en, din, dout, registered, parameter W), instantiated N times in a generate.
// - Integrators, phase/settle counters, scaler/saturator and output handshake stay in this module.
// TESTING
// - Reset, then pdm_in = 1 constantly -> settled samples are all 32767; first pcm_valid is on the
//   strobe-aligned edge after N dropped outputs; overrun = 0 with pcm_ready = 1.
// - pdm_in = 0 constantly -> pcm_out = -32768 on every sample.
// - pdm_in alternating 1,0 -> pcm_out = 0 on every settled sample.
// - Loopback pdm_wave_gen.dout -> pdm_in, 2 MHz addr_clk:
//   - Output is a sinusoid with period 8000/64 = 125 samples.
//   - Compare against a golden CIC model fed the same wavetable bits; the match must be bit-exact.
// - Hold pcm_ready = 0 across two strobes -> overrun = 1 after the second load, pcm_out equals the second
//   sample; then pcm_ready = 1 for one edge -> pcm_valid = 0, overrun stays 1.
// - Assert reset for 1 edge mid-frame at phase 30 -> pcm_valid = 0 next edge. The next valid sample appears
//   only after N+1 full DECIM periods plus N+2 edges, with value equal to a fresh-start model.

Source files
------------

// File: rtl/pdm_pkg.sv
// Shared constants and helpers for the PDM receive path (wavetable geometry, CIC defaults).
`ifndef PDM_PKG_SV
`define PDM_PKG_SV

// Internal CIC word width: N*log2(R) bits of growth plus sign and one bit for the +/-1 input.
`define PDM_CIC_ACC_W(n, decim) ((n) * pdm_pkg::clog2(decim) + 2)

package pdm_pkg;

  localparam int PDM_WORD_W  = 8;
  localparam int PDM_WT_SIZE = 1000;

  localparam int CIC_N     = 3;
  localparam int CIC_DECIM = 64;
  localparam int CIC_OUT_W = 16;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

`endif

// File: rtl/pdm_cic_decimator_comb.sv
// One registered CIC comb section with unit differential delay.
module cic_comb_stage #(
  parameter int W = 20
) (
  input  logic                addr_clk,
  input  logic                reset,
  input  logic                en,
  input  logic signed [W-1:0] din,
  output logic signed [W-1:0] dout
);

  logic signed [W-1:0] dly_p0;

  always_ff @(posedge addr_clk) begin
    if (reset) begin
      dly_p0 <= '0;
      dout   <= '0;
    end else if (en) begin
      dout   <= din - dly_p0;
      dly_p0 <= din;
    end
  end

endmodule

// File: rtl/pdm_cic_decimator.sv
// PDM receive front end: 1-bit stream -> N-stage CIC decimator -> saturated signed PCM on valid/ready.
module pdm_cic_decimator
  import pdm_pkg::*;
#(
  parameter int N     = CIC_N,
  parameter int DECIM = CIC_DECIM,
  parameter int OUT_W = CIC_OUT_W
) (
  input  logic                    addr_clk,
  input  logic                    reset,
  input  logic                    pdm_in,
  output logic signed [OUT_W-1:0] pcm_out,
  output logic                    pcm_valid,
  input  logic                    pcm_ready,
  output logic                    overrun
);

  localparam int ACC_W = `PDM_CIC_ACC_W(N, DECIM);
  localparam int PH_W  = clog2(DECIM);
  localparam int SET_W = clog2(N + 1);
  localparam int SHIFT = N * clog2(DECIM) + 1 - OUT_W;

  localparam logic signed [ACC_W-1:0] SAT_HI = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_LO = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  function automatic logic signed [OUT_W-1:0] scale_sat(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] s;
    s = v >>> SHIFT;
    if (s > SAT_HI) return SAT_HI[OUT_W-1:0];
    if (s < SAT_LO) return SAT_LO[OUT_W-1:0];
    return s[OUT_W-1:0];
  endfunction

  logic                    pdm_q;
  logic signed [ACC_W-1:0] x_p0;
  logic signed [ACC_W-1:0] integ [N];
  logic signed [ACC_W-1:0] comb_d [N];
  logic [PH_W-1:0]         phase;
  logic                    strobe;
  logic [N-1:0]            en_pipe;
  logic [SET_W-1:0]        settle;
  logic                    settled;
  logic signed [OUT_W-1:0] sat_p1;
  logic                    vld_p1;

  // Input register and +/-1 mapping (pdm_q = 0 -> all ones = -1).
  always_ff @(posedge addr_clk) begin
    if (reset) pdm_q <= 1'b0;
    else       pdm_q <= pdm_in;
  end

  assign x_p0 = {{(ACC_W-1){~pdm_q}}, 1'b1};

  // Integrators at the bit rate; modulo-2^ACC_W wrap is harmless because the combs undo it.
  always_ff @(posedge addr_clk) begin
    if (reset) begin
      for (int k = 0; k < N; k++) integ[k] <= '0;
    end else begin
      integ[0] <= integ[0] + x_p0;
      for (int k = 1; k < N; k++) integ[k] <= integ[k] + integ[k-1];
    end
  end

  assign strobe  = (phase == PH_W'(DECIM - 1));
  assign settled = (settle == SET_W'(N));

  always_ff @(posedge addr_clk) begin
    if (reset) begin
      phase   <= '0;
      en_pipe <= '0;
    end else begin
      phase      <= phase + 1'b1;
      en_pipe[0] <= strobe;
      for (int k = 1; k < N; k++) en_pipe[k] <= en_pipe[k-1];
    end
  end

  // Comb chain: one stage per edge, enable travels with the data.
  for (genvar k = 0; k < N; k++) begin : g_comb
    if (k == 0) begin : g_first
      cic_comb_stage #(.W(ACC_W)) u_stage (
        .addr_clk (addr_clk),
        .reset    (reset),
        .en       (strobe),
        .din      (integ[N-1]),
        .dout     (comb_d[0])
      );
    end else begin : g_rest
      cic_comb_stage #(.W(ACC_W)) u_stage (
        .addr_clk (addr_clk),
        .reset    (reset),
        .en       (en_pipe[k-1]),
        .din      (comb_d[k-1]),
        .dout     (comb_d[k])
      );
    end
  end

  // Scale/saturate stage; the first N results are dropped while comb delays fill.
  always_ff @(posedge addr_clk) begin
    if (reset) begin
      settle <= '0;
      sat_p1 <= '0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= en_pipe[N-1] && settled;
      if (en_pipe[N-1]) begin
        if (settled) sat_p1 <= scale_sat(comb_d[N-1]);
        else         settle <= settle + 1'b1;
      end
    end
  end

  // Output register and handshake; a load onto an unaccepted sample overwrites it and flags overrun.
  always_ff @(posedge addr_clk) begin
    if (reset) begin
      pcm_out   <= '0;
      pcm_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (vld_p1) begin
      pcm_out   <= sat_p1;
      pcm_valid <= 1'b1;
      if (pcm_valid && !pcm_ready) overrun <= 1'b1;
    end else if (pcm_valid && pcm_ready) begin
      pcm_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pdm_cic_decimator.sv
// Scoreboard bench: a golden unwrapped CIC model predicts each PCM sample and its load edge.
`timescale 1ns/1ps
module tb_pdm_cic_decimator;
  import pdm_pkg::*;

  localparam int N     = CIC_N;
  localparam int DECIM = CIC_DECIM;
  localparam int OUT_W = CIC_OUT_W;
  localparam int SHIFT = N * clog2(DECIM) + 1 - OUT_W;
  localparam longint SAT_HI = (longint'(1) << (OUT_W - 1)) - 1;
  localparam longint SAT_LO = -(longint'(1) << (OUT_W - 1));
  localparam int WT_BITS = PDM_WT_SIZE * PDM_WORD_W;

  logic                    addr_clk = 1'b0;
  logic                    reset = 1'b1;
  logic                    pdm_in = 1'b1;
  logic                    pcm_ready = 1'b1;
  logic signed [OUT_W-1:0] pcm_out;
  logic                    pcm_valid;
  logic                    overrun;

  pdm_cic_decimator #(.N(N), .DECIM(DECIM), .OUT_W(OUT_W)) dut (
    .addr_clk  (addr_clk),
    .reset     (reset),
    .pdm_in    (pdm_in),
    .pcm_out   (pcm_out),
    .pcm_valid (pcm_valid),
    .pcm_ready (pcm_ready),
    .overrun   (overrun)
  );

  // 2 MHz bit clock.
  always #250 addr_clk = ~addr_clk;

  typedef struct {
    longint edge_no;
    longint value;
  } sample_t;

  sample_t sb[$];
  int      vectors = 0;
  int      miscompares = 0;
  longint  ecnt = 0;
  longint  isum [N];
  longint  snap [N+1];
  logic    exp_valid = 1'b0;
  logic    exp_ovr = 1'b0;
  longint  exp_out = 0;
  logic    rst_e = 1'b1;
  logic    pdm_e = 1'b1;
  logic    rdy_e = 1'b1;
  int      wt_pos = 0;
  logic [PDM_WORD_W-1:0] wt [PDM_WT_SIZE];

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", tag, ecnt, obs, exp);
    end
  endtask

  function automatic longint sat_scale(input longint y);
    longint s;
    s = y >>> SHIFT;
    if (s > SAT_HI) return SAT_HI;
    if (s < SAT_LO) return SAT_LO;
    return s;
  endfunction

  task automatic integrate(input longint v);
    isum[0] += v;
    for (int k = 1; k < N; k++) isum[k] += isum[k-1];
  endtask

  // N-th order difference of the decimated N-fold running sums.
  task automatic decimate();
    longint d [N+1];
    longint j;
    for (int i = N; i > 0; i--) snap[i] = snap[i-1];
    snap[0] = isum[N-1];
    d = snap;
    for (int k = 1; k <= N; k++)
      for (int i = 0; i <= N - k; i++) d[i] = d[i] - d[i+1];
    j = (ecnt + 1 + N) / DECIM;
    if (j > N) sb.push_back('{edge_no: j * DECIM + N + 1, value: sat_scale(d[0])});
  endtask

  // Monitor: replays the edge that just happened with the inputs it sampled, then compares.
  initial begin : monitor
    forever begin
      @(negedge addr_clk);
      if (rst_e) begin
        ecnt = 0;
        sb.delete();
        exp_valid = 1'b0;
        exp_ovr   = 1'b0;
        exp_out   = 0;
        for (int i = 0; i <= N; i++) snap[i] = 0;
        for (int i = 0; i < N; i++) isum[i] = 0;
        integrate(-1);
      end else begin
        ecnt++;
        integrate(pdm_e ? 1 : -1);
        if ((ecnt + 1 + N) % DECIM == 0) decimate();
        if (sb.size() > 0 && sb[0].edge_no == ecnt) begin
          if (exp_valid && !rdy_e) exp_ovr = 1'b1;
          exp_valid = 1'b1;
          exp_out   = sb[0].value;
          void'(sb.pop_front());
        end else if (exp_valid && rdy_e) begin
          exp_valid = 1'b0;
        end
      end
      check_eq("pcm_valid", longint'(pcm_valid), longint'(exp_valid));
      check_eq("overrun", longint'(overrun), longint'(exp_ovr));
      check_eq("pcm_out", longint'(pcm_out), exp_out);
      rst_e = reset;
      pdm_e = pdm_in;
      rdy_e = pcm_ready;
    end
  end

  // mode: 0 const 0, 1 const 1, 2 alternate, 3 random, 4 wavetable loopback
  task automatic run(input int cycles, input int mode);
    for (int c = 0; c < cycles; c++) begin
      @(posedge addr_clk);
      #1;
      case (mode)
        0: pdm_in = 1'b0;
        1: pdm_in = 1'b1;
        2: pdm_in = ~pdm_in;
        3: pdm_in = 1'($urandom_range(0, 1));
        default: begin
          pdm_in = wt[wt_pos / PDM_WORD_W][PDM_WORD_W - 1 - (wt_pos % PDM_WORD_W)];
          wt_pos = (wt_pos + 1) % WT_BITS;
        end
      endcase
    end
  endtask

  initial begin : driver
    real acc;
    real tgt;
    logic b;
    // First-order sigma-delta sine, one period per table pass, packed MSB first.
    acc = 0.0;
    for (int i = 0; i < WT_BITS; i++) begin
      tgt = 0.5 * $sin(2.0 * 3.14159265358979 * i / WT_BITS);
      b = (acc >= 0.0);
      acc = acc + tgt - (b ? 1.0 : -1.0);
      wt[i / PDM_WORD_W][PDM_WORD_W - 1 - (i % PDM_WORD_W)] = b;
    end

    reset = 1'b1;
    pcm_ready = 1'b1;
    pdm_in = 1'b1;
    repeat (3) @(posedge addr_clk);
    #1 reset = 1'b0;

    run(8 * DECIM, 1);
    run(8 * DECIM, 0);
    run(8 * DECIM, 2);
    run(3 * DECIM, 3);

    // Two loads without acceptance, a single accept, then overrun must stay sticky.
    pcm_ready = 1'b0;
    run(2 * DECIM + 10, 3);
    pcm_ready = 1'b1;
    run(1, 3);
    pcm_ready = 1'b0;
    run(20, 3);
    pcm_ready = 1'b1;

    run(WT_BITS + 4 * DECIM, 4);

    // Hold a sample unaccepted, then reset mid-frame at phase 30.
    pcm_ready = 1'b0;
    run(DECIM, 1);
    for (int g = 0; g < 2 * DECIM && ((ecnt + 1) % DECIM) != 30; g++) run(1, 1);
    reset = 1'b1;
    run(1, 3);
    reset = 1'b0;
    pcm_ready = 1'b1;
    run((N + 3) * DECIM, 3);
    run(4 * DECIM, 1);

    run(4, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
